// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared state encoding, command bytes and snapshot sizes for mips_debug_unit
package debug_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_STEP,
    S_DUMP_PC,
    S_DUMP_CYC,
    S_DUMP_REG,
    S_DUMP_LATCH,
    S_HALTED
  } dbg_state_t;

  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;

  // PC + cycle count + 32 GPRs, optionally followed by the 68 latch bytes
  localparam int SNAP_BYTES_BASE  = 4 + 4 + 32 * 4;
  localparam int SNAP_BYTES_LATCH = SNAP_BYTES_BASE + 544 / 8;

endpackage

// File: rtl/debug_word_serializer.sv
// rtl/debug_word_serializer.sv - emits a loaded word LSB byte first over valid/ready, pulses done on the last byte
module debug_word_serializer #(
  parameter int LEN = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_load,
  input  logic [LEN-1:0] i_word,
  output logic           o_tx_valid,
  output logic [7:0]     o_tx_data,
  input  logic           i_tx_ready,
  output logic           o_done
);

  localparam int NBYTES = LEN / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [LEN-1:0] shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic           xfer;

  assign xfer       = valid_q & i_tx_ready;
  assign o_done     = xfer && (cnt_q == '0);
  assign o_tx_valid = valid_q;
  assign o_tx_data  = shift_q[7:0];

  // A load in the same cycle as the final transfer chains words with no gap
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (xfer) begin
      shift_d = shift_q >> 8;
      cnt_d   = cnt_q - CW'(1);
      if (cnt_q == '0) valid_d = 1'b0;
    end
    if (i_load) begin
      shift_d = i_word;
      cnt_d   = CW'(NBYTES - 1);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/mips_debug_unit.sv
// rtl/mips_debug_unit.sv - run/step pipeline gating and snapshot dump; DEBUG_LATCH_DUMP_EN adds the latch dump
module mips_debug_unit
  import debug_pkg::*;
#(
  parameter int LEN                  = 32,
  parameter int NB_ADDRESS_REGISTROS = 5,
  parameter int NB_LATCHES           = 544,
  parameter int DRAIN_CYCLES         = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_rx_valid,
  input  logic [7:0]                      i_rx_data,
  output logic                            o_tx_valid,
  output logic [7:0]                      o_tx_data,
  input  logic                            i_tx_ready,
  output logic                            o_pipe_en,
  input  logic                            i_flag_halt,
  input  logic [LEN-1:0]                  i_pc,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_reg_addr,
  input  logic [LEN-1:0]                  i_reg_data,
  input  logic [NB_LATCHES-1:0]           i_latches,
  output logic                            o_halted
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  dbg_state_t                      state_q, state_d;
  logic                            pipe_en_q, pipe_en_d;
  logic                            halt_seen_q, halt_seen_d;
  logic                            pend_q, pend_d;
  logic [DW-1:0]                   drain_q, drain_d;
  logic [LEN-1:0]                  cyc_q, cyc_d;
  logic [NB_ADDRESS_REGISTROS-1:0] reg_idx_q, reg_idx_d;
  logic                            ser_load, ser_done;
  logic [LEN-1:0]                  ser_word;
  dbg_state_t                      end_state;

`ifdef DEBUG_LATCH_DUMP_EN
  localparam int CHUNKS = NB_LATCHES / LEN;
  localparam int CHW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  logic [NB_LATCHES-1:0] latch_q, latch_d;
  logic [CHW-1:0]        chunk_q, chunk_d;
`else
  logic unused_latches;
  assign unused_latches = ^i_latches;
`endif

  assign end_state  = halt_seen_q ? S_HALTED : S_IDLE;
  assign o_pipe_en  = pipe_en_q;
  assign o_reg_addr = reg_idx_q;
  assign o_halted   = (state_q == S_HALTED);
  assign cyc_d      = cyc_q + LEN'(pipe_en_q);

  // pend_q marks a word that must be loaded next cycle, after the source settles
  always_comb begin
    state_d     = state_q;
    halt_seen_d = halt_seen_q;
    pend_d      = pend_q;
    drain_d     = drain_q;
    reg_idx_d   = reg_idx_q;
    ser_load    = 1'b0;
    ser_word    = '0;
`ifdef DEBUG_LATCH_DUMP_EN
    latch_d     = latch_q;
    chunk_d     = chunk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_rx_valid && i_rx_data == CMD_RUN) state_d = S_RUN;
        else if (i_rx_valid && i_rx_data == CMD_STEP) state_d = S_STEP;
      end
      S_RUN: begin
        if (i_flag_halt) begin
          state_d     = S_DRAIN;
          drain_d     = DW'(DRAIN_CYCLES - 1);
          halt_seen_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_DUMP_PC;
          pend_d  = 1'b1;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      S_STEP: begin
        if (i_flag_halt) halt_seen_d = 1'b1;
        state_d = S_DUMP_PC;
        pend_d  = 1'b1;
      end
      S_DUMP_PC: begin
        if (pend_q) begin
          ser_load = 1'b1;
          ser_word = i_pc;
          pend_d   = 1'b0;
        end else if (ser_done) begin
          state_d  = S_DUMP_CYC;
          ser_load = 1'b1;
          ser_word = cyc_q;
        end
      end
      S_DUMP_CYC: begin
        if (ser_done) begin
          state_d   = S_DUMP_REG;
          reg_idx_d = '0;
          pend_d    = 1'b1;
        end
      end
      S_DUMP_REG: begin
        if (pend_q) begin
          ser_load = 1'b1;
          ser_word = i_reg_data;
          pend_d   = 1'b0;
        end else if (ser_done) begin
          if (reg_idx_q == '1) begin
`ifdef DEBUG_LATCH_DUMP_EN
            state_d  = S_DUMP_LATCH;
            ser_load = 1'b1;
            ser_word = i_latches[LEN-1:0];
            latch_d  = i_latches >> LEN;
            chunk_d  = CHW'(CHUNKS - 1);
`else
            state_d  = end_state;
`endif
          end else begin
            reg_idx_d = reg_idx_q + NB_ADDRESS_REGISTROS'(1);
            pend_d    = 1'b1;
          end
        end
      end
`ifdef DEBUG_LATCH_DUMP_EN
      S_DUMP_LATCH: begin
        if (ser_done) begin
          if (chunk_q == '0) begin
            state_d = end_state;
          end else begin
            ser_load = 1'b1;
            ser_word = latch_q[LEN-1:0];
            latch_d  = latch_q >> LEN;
            chunk_d  = chunk_q - CHW'(1);
          end
        end
      end
`endif
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    pipe_en_d = (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_STEP);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      pipe_en_q   <= 1'b0;
      halt_seen_q <= 1'b0;
      pend_q      <= 1'b0;
      drain_q     <= '0;
      cyc_q       <= '0;
      reg_idx_q   <= '0;
`ifdef DEBUG_LATCH_DUMP_EN
      latch_q     <= '0;
      chunk_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pipe_en_q   <= pipe_en_d;
      halt_seen_q <= halt_seen_d;
      pend_q      <= pend_d;
      drain_q     <= drain_d;
      cyc_q       <= cyc_d;
      reg_idx_q   <= reg_idx_d;
`ifdef DEBUG_LATCH_DUMP_EN
      latch_q     <= latch_d;
      chunk_q     <= chunk_d;
`endif
    end
  end

  debug_word_serializer #(.LEN(LEN)) u_ser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (ser_load),
    .i_word     (ser_word),
    .o_tx_valid (o_tx_valid),
    .o_tx_data  (o_tx_data),
    .i_tx_ready (i_tx_ready),
    .o_done     (ser_done)
  );

endmodule
